mmio_ctrl: RTL
==============

MMIO_CTRL -- requirements
Module: mmio_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset, ports: clk  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-002 SHALL have ports: mem_cmd  in  2  CPU command (00 NOP, 10 READ, 01 WRITE); mem_addr  in  9  CPU word address; wr_data  in  16  CPU store data.
REQ-003 SHALL have ports: ram_rdata  in  16  RAM data port output, updated on negedge; sw  in  8  raw slide switches.
REQ-004 SHALL have ports: ram_write  out  1  RAM write enable; ram_addr  out  8  RAM data/write address; ram_wdata  out  16  RAM write data.
REQ-005 SHALL have ports: rd_data  out  16  registered read data to CPU; rd_valid  out  1  rd_data holds a new read result; led  out  8  LED register; err  out  1  sticky bad-access flag.

Function
REQ-006 Address decode SHALL be: mem_addr[8]=0 -> RAM word mem_addr[7:0]; 0x100 -> LED register (write-only); 0x140 -> switch port (read-only); every other address with mem_addr[8]=1 -> unmapped.
REQ-007 ram_addr SHALL equal mem_addr[7:0] and ram_wdata SHALL equal wr_data combinationally at all times.
REQ-008 ram_write SHALL be 1 only when mem_cmd=WRITE and mem_addr[8]=0, combinationally, so the RAM commits on the negedge of the same cycle.
REQ-009 WRITE to 0x100 SHALL load led<=wr_data[7:0] at the next rising edge; WRITE to 0x140 or an unmapped address SHALL change no storage.
REQ-010 READ sampled in cycle N SHALL load rd_data at the rising edge ending cycle N and SHALL set rd_valid=1 for exactly cycle N+1; latency is one cycle for every source.
REQ-011 READ source SHALL be: RAM -> ram_rdata; 0x140 -> {8'h00, sw_sync}; 0x100 or unmapped -> 16'h0000.
REQ-012 sw SHALL pass through a two-flop synchronizer; the value returned by a READ SHALL be the synchronizer output at the sampling edge (two-cycle input latency).
REQ-013 rd_data SHALL hold its last value when no READ occurs; rd_valid SHALL be 0 in any cycle not directly following a READ.
REQ-014 err SHALL set at the next edge on: READ or WRITE to an unmapped address, READ of 0x100, WRITE of 0x140, or mem_cmd=2'b11; err SHALL stay set until reset.
REQ-015 mem_cmd=2'b11 SHALL otherwise behave as NOP: no write, no rd_valid.
REQ-016 Back-to-back commands SHALL be accepted every cycle with no stall; each READ SHALL produce its own one-cycle rd_valid pulse.

Reset
REQ-017 Reset SHALL, at the next rising edge, clear led, rd_data, rd_valid, err and both synchronizer stages to 0.
REQ-018 While reset=1, ram_write SHALL be forced to 0 and commands SHALL be ignored; a READ sampled in the reset cycle SHALL produce no rd_valid.

Configuration
REQ-019 Macro MMIO_HEX_EN SHALL, when defined, add output hex (16 bits), a register at address 0x180 written by WRITE (hex<=wr_data), read back by READ, reset to 0; 0x180 SHALL then not set err.
REQ-020 Without MMIO_HEX_EN, the hex port and register SHALL not exist and 0x180 SHALL be unmapped per REQ-014.

Structure
REQ-021 Package mmio_pkg SHALL hold the mem_cmd enum (M_NOP, M_READ, M_WRITE) and the address constants LED_ADDR=9'h100, SW_ADDR=9'h140, HEX_ADDR=9'h180.
REQ-022 The switch synchronizer SHALL be a sub-module sync2 (parameterised width, clk/reset, reset value 0); all other logic SHALL live in mmio_ctrl.

Verification
REQ-023 Reset, then WRITE 0x100 data 16'h00A5 -> led=8'hA5 next cycle, ram_write=0, err=0.
REQ-024 WRITE 0x012 data 16'hBEEF, then READ 0x012 -> ram_write=1 only in the write cycle; rd_data=16'hBEEF with rd_valid=1 one cycle after the READ.
REQ-025 sw=8'h3C held three cycles, READ 0x140 -> rd_data=16'h003C, rd_valid one cycle; sw changed to 8'hFF one cycle before a READ -> rd_data still 16'h003C.
REQ-026 READ 0x1F0, then mem_cmd=2'b11 -> rd_data=16'h0000, err=1 and stays 1 through 20 NOP cycles; reset clears it.
REQ-027 READ 0x012 issued in the same cycle reset=1 -> rd_valid=0 next cycle, rd_data=0.
REQ-028 With MMIO_HEX_EN defined: WRITE 0x180 data 16'h1234, READ 0x180 -> hex=16'h1234, rd_data=16'h1234, err=0.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared types and address map for the mmio_ctrl memory-mapped I/O block.
package mmio_pkg;

    typedef enum logic [1:0] {
        M_NOP   = 2'b00,
        M_READ  = 2'b10,
        M_WRITE = 2'b01
    } mem_cmd_e;

    typedef enum logic [2:0] {
        R_RAM,
        R_LED,
        R_SW,
        R_HEX,
        R_NONE
    } region_e;

    localparam logic [8:0] LED_ADDR = 9'h100;
    localparam logic [8:0] SW_ADDR  = 9'h140;
    localparam logic [8:0] HEX_ADDR = 9'h180;

endpackage

// File: rtl/mmio_sync2.sv
// Two-flop synchronizer for asynchronous level inputs; both stages reset to 0.
module sync2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // NOTE: sequential state uses non-blocking assignments so both stages sample the old values on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mmio_ctrl.sv
// CPU-side MMIO decoder: RAM window, LED register, synchronized switch port, sticky error flag.
// Optional 16-bit hex display register at 0x180 enabled by defining MMIO_HEX_EN.
module mmio_ctrl
    import mmio_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  mem_cmd,
    input  logic [8:0]  mem_addr,
    input  logic [15:0] wr_data,
    input  logic [15:0] ram_rdata,
    input  logic [7:0]  sw,
    output logic        ram_write,
    output logic [7:0]  ram_addr,
    output logic [15:0] ram_wdata,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic [7:0]  led,
    output logic        err
`ifdef MMIO_HEX_EN
    ,
    output logic [15:0] hex
`endif
);

    logic [7:0]  sw_sync;
    region_e     region;
    logic        is_read;
    logic        is_write;
    logic        bad_access;
    logic [15:0] read_mux;

    sync2 #(.WIDTH(8)) u_sw_sync (
        .clk   (clk),
        .reset (reset),
        .d     (sw),
        .q     (sw_sync)
    );

    assign ram_addr  = mem_addr[7:0];
    assign ram_wdata = wr_data;
    assign is_read   = (mem_cmd == M_READ);
    assign is_write  = (mem_cmd == M_WRITE);
    // The RAM commits on the falling edge, so the enable must already be qualified by reset.
    assign ram_write = !reset && is_write && (region == R_RAM);

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        region     = R_NONE;
        read_mux   = 16'h0000;
        bad_access = 1'b0;

        if (!mem_addr[8])
            region = R_RAM;
        else if (mem_addr == LED_ADDR)
            region = R_LED;
        else if (mem_addr == SW_ADDR)
            region = R_SW;
`ifdef MMIO_HEX_EN
        else if (mem_addr == HEX_ADDR)
            region = R_HEX;
`endif

        case (region)
            R_RAM:   read_mux = ram_rdata;
            R_SW:    read_mux = {8'h00, sw_sync};
`ifdef MMIO_HEX_EN
            R_HEX:   read_mux = hex;
`endif
            default: read_mux = 16'h0000;
        endcase

        if (mem_cmd == 2'b11)
            bad_access = 1'b1;
        else if (is_read && (region == R_LED || region == R_NONE))
            bad_access = 1'b1;
        else if (is_write && (region == R_SW || region == R_NONE))
            bad_access = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led      <= 8'h00;
            rd_data  <= 16'h0000;
            rd_valid <= 1'b0;
            err      <= 1'b0;
        end else begin
            rd_valid <= is_read;
            if (is_read)
                rd_data <= read_mux;
            if (is_write && region == R_LED)
                led <= wr_data[7:0];
            if (bad_access)
                err <= 1'b1;
        end
    end

`ifdef MMIO_HEX_EN
    always_ff @(posedge clk) begin
        if (reset)
            hex <= 16'h0000;
        else if (is_write && region == R_HEX)
            hex <= wr_data;
    end
`endif

endmodule
